// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: op codes, FSM state encoding and muldiv modes.
// The DIV state only exists when SEQ_ALU_DIV_EN is defined.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ANDN = 4'd3;
  localparam logic [3:0] OP_ROL  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_ROR  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SEQ  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLE  = 4'd10;
  localparam logic [3:0] OP_SCO  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_DIV  = 4'd13;
  localparam logic [3:0] OP_REM  = 4'd14;
  localparam logic [3:0] OP_BTR  = 4'd15;

`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd3
  } state_e;
`endif

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_REM = 2'd2
  } md_mode_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// The divider datapath is compiled in only when SEQ_ALU_DIV_EN is defined.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  md_mode_e         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_mode_e         mode_q, mode_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;  // multiplicand (MUL) or divisor (DIV), fixed while busy
  logic [WIDTH-1:0] acc_q, acc_d;    // product high half / partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;      // multiplier -> product low half / dividend -> quotient
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0] trial;
  assign trial = {acc_q, sh_q[WIDTH-1]} - {1'b0, opnd_q};
`endif

  always_comb begin
    // NOTE: every signal this block writes gets a default first, so no path leaves one unassigned and infers a latch.
    mode_d = mode_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    sh_d   = sh_q;
    done   = 1'b0;
    if (start && !busy_q) begin
      mode_d = mode;
      busy_d = 1'b1;
      cnt_d  = '0;
      acc_d  = '0;
      if (mode == MD_MUL) begin
        opnd_d = a;
        sh_d   = b;
      end else begin
        opnd_d = b;
        sh_d   = a;
      end
    end else if (busy_q) begin
`ifdef SEQ_ALU_DIV_EN
      if (mode_q != MD_MUL) begin
        // A negative trial difference means restore: keep the shifted remainder, quotient bit 0.
        acc_d = trial[WIDTH] ? {acc_q[WIDTH-2:0], sh_q[WIDTH-1]} : trial[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], ~trial[WIDTH]};
      end else
`endif
      begin
        acc_d = sum[WIDTH:1];
        sh_d  = {sum[0], sh_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        done   = 1'b1;
      end
    end
  end

  // Final value is taken from the next-state terms so it is ready on the done cycle.
  assign res  = (mode_q == MD_REM) ? acc_d : sh_d;
  assign busy = busy_q;

  // NOTE: flops use non-blocking assignments so each one samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MD_MUL;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
    end else begin
      mode_q <= mode_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
      sh_q   <= sh_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops plus iterative MUL and (with SEQ_ALU_DIV_EN) DIV/REM,
// valid/ready handshake on both sides, registered result and z/n/p/err flags.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             p,
  output logic             err
);

  localparam logic [SHW:0] W_AMT = WIDTH[SHW:0];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d, n_q, n_d, p_q, p_d, err_q, err_d;

  logic             md_start, md_busy, md_done;
  md_mode_e         md_mode;
  logic [WIDTH-1:0] md_res;

  logic [SHW-1:0]   shamt;
  logic [SHW:0]     shamt_inv;
  logic [WIDTH:0]   add_full;
  logic             cmp;
  logic [WIDTH-1:0] alu_res;

  assign shamt     = b[SHW-1:0];
  assign shamt_inv = W_AMT - {1'b0, shamt};
  assign add_full  = {1'b0, a} + {1'b0, b};

  always_comb begin
    alu_res = '0;
    cmp     = 1'b0;
    case (op)
      OP_ADD:  alu_res = add_full[WIDTH-1:0];
      OP_SUB:  alu_res = a - b;
      OP_XOR:  alu_res = a ^ b;
      OP_ANDN: alu_res = a & ~b;
      // A shift by the full width yields zero, which makes rotate-by-0 come out right.
      OP_ROL:  alu_res = (a << shamt) | (a >> shamt_inv);
      OP_SLL:  alu_res = a << shamt;
      OP_ROR:  alu_res = (a >> shamt) | (a << shamt_inv);
      OP_SRL:  alu_res = a >> shamt;
      OP_SEQ:  cmp = (a == b);
      OP_SLT:  cmp = ($signed(a) < $signed(b));
      OP_SLE:  cmp = ($signed(a) <= $signed(b));
      OP_SCO:  cmp = add_full[WIDTH];
      OP_BTR: begin
        for (int i = 0; i < WIDTH; i++) alu_res[i] = a[WIDTH-1-i];
      end
      default: alu_res = '0;
    endcase
    if (op inside {OP_SEQ, OP_SLT, OP_SLE, OP_SCO}) alu_res = {{(WIDTH-1){1'b0}}, cmp};
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .mode  (md_mode),
    .a     (a),
    .b     (b),
    .busy  (md_busy),
    .done  (md_done),
    .res   (md_res)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    err_d    = err_q;
    md_start = 1'b0;
    md_mode  = MD_MUL;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (op)
            OP_MUL: begin
              state_d  = MUL;
              md_start = ~md_busy;
            end
            OP_DIV, OP_REM: begin
`ifdef SEQ_ALU_DIV_EN
              if (b == '0) begin
                state_d  = DONE;
                result_d = '1;
                err_d    = 1'b1;
              end else begin
                state_d  = DIV;
                md_start = ~md_busy;
                md_mode  = (op == OP_REM) ? MD_REM : MD_DIV;
              end
`else
              state_d  = DONE;
              result_d = '0;
              err_d    = 1'b1;
`endif
            end
            default: begin
              state_d  = DONE;
              result_d = alu_res;
              err_d    = 1'b0;
            end
          endcase
        end
      end
`ifdef SEQ_ALU_DIV_EN
      DIV,
`endif
      MUL: begin
        if (md_done) begin
          state_d  = DONE;
          result_d = md_res;
          err_d    = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flags follow the result they are registered with, so they hold together under backpressure.
    z_d = (result_d == '0);
    n_d = result_d[WIDTH-1] & ~z_d;
    p_d = ~n_d & ~z_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      z_q      <= 1'b1;
      n_q      <= 1'b0;
      p_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      p_q      <= p_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign z         = z_q;
  assign n         = n_q;
  assign p         = p_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=16): directed literal cases plus a randomized
// run compared every cycle against a latency-level reference model. Honors SEQ_ALU_DIV_EN.
`timescale 1ns/1ps
module tb_seq_alu;

`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  op = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid, z, n, p, err;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .z         (z),
    .n         (n),
    .p         (p),
    .err       (err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_result(input logic [3:0] f_op, input logic [15:0] fa, input logic [15:0] fb);
    int unsigned ua, ub, s, r;
    int sa, sb;
    ua = fa;
    ub = fb;
    s  = ub % 16;
    sa = (ua >= 32768) ? int'(ua) - 65536 : int'(ua);
    sb = (ub >= 32768) ? int'(ub) - 65536 : int'(ub);
    r  = 0;
    case (f_op)
      4'd0:  r = ua + ub;
      4'd1:  r = ua - ub;
      4'd2:  r = ua ^ ub;
      4'd3:  r = ua & ~ub;
      4'd4:  r = (ua << s) | (ua >> (16 - s));
      4'd5:  r = ua << s;
      4'd6:  r = (ua >> s) | (ua << (16 - s));
      4'd7:  r = ua >> s;
      4'd8:  r = (ua == ub) ? 1 : 0;
      4'd9:  r = (sa < sb) ? 1 : 0;
      4'd10: r = (sa <= sb) ? 1 : 0;
      4'd11: r = (ua + ub > 65535) ? 1 : 0;
      4'd12: r = ua * ub;
      4'd13: r = !DIV_EN ? 0 : (ub == 0 ? 65535 : ua / ub);
      4'd14: r = !DIV_EN ? 0 : (ub == 0 ? 65535 : ua % ub);
      default: begin
        for (int i = 0; i < 16; i++) if (ua[i]) r = r | (32'd1 << (15 - i));
      end
    endcase
    return r[15:0];
  endfunction

  function automatic logic ref_err(input logic [3:0] f_op, input logic [15:0] fb);
    return (f_op == 4'd13 || f_op == 4'd14) && (!DIV_EN || fb == 16'd0);
  endfunction

  function automatic int ref_lat(input logic [3:0] f_op, input logic [15:0] fb);
    if (f_op == 4'd12) return 17;
    if ((f_op == 4'd13 || f_op == 4'd14) && DIV_EN && fb != 16'd0) return 17;
    return 1;
  endfunction

  // Model state: idle, waiting out a latency, or holding a result until taken.
  logic        m_valid = 1'b0;
  logic        m_busy = 1'b0;
  int          m_wait = 0;
  logic [15:0] m_res = '0;
  logic        m_err = 1'b0;
  logic [15:0] p_res = '0;
  logic        p_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_wait  <= 0;
      m_res   <= '0;
      m_err   <= 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_busy) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_res   <= p_res;
        m_err   <= p_err;
      end
    end else if (in_valid) begin
      if (ref_lat(op, b) == 1) begin
        m_valid <= 1'b1;
        m_res   <= ref_result(op, a, b);
        m_err   <= ref_err(op, b);
      end else begin
        m_busy <= 1'b1;
        m_wait <= ref_lat(op, b) - 1;
        p_res  <= ref_result(op, a, b);
        p_err  <= ref_err(op, b);
      end
    end
  end

  always @(negedge clk) begin
    check("model_in_ready", in_ready, !m_valid && !m_busy);
    check("model_out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("model_result", result, m_res);
      check("model_err", err, m_err);
      check("model_z", z, m_res == 16'd0);
      check("model_n", n, m_res >= 16'h8000);
      check("model_p", p, m_res != 16'd0 && m_res < 16'h8000);
    end
  end

  // ---------------- directed helper ----------------
  task automatic run_op(input string name, input logic [3:0] t_op, input logic [15:0] t_a,
                        input logic [15:0] t_b, input logic [15:0] exp_res, input logic exp_err,
                        input int exp_lat, input int hold);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_ready"}, in_ready, 1);
    op = t_op; a = t_a; b = t_b;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      // Requests while busy must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_result"}, result, exp_res);
    check({name, "_err"}, err, exp_err);
    check({name, "_n"}, n, exp_res[15]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_result"}, result, exp_res);
      check({name, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, "_idle"}, in_ready, 1);
    check({name, "_drop_valid"}, out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 16'h0000);
    check("rst_z", z, 1);
    check("rst_n_flag", n, 0);
    check("rst_p", p, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_ready", in_ready, 1);

    run_op("add",   4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1, 0);
    run_op("mul",   4'd12, 16'h0123, 16'h0010, 16'h1230, 1'b0, 17, 0);
    if (DIV_EN) begin
      run_op("div",  4'd13, 16'd1000, 16'd7, 16'd142,  1'b0, 17, 0);
      run_op("rem",  4'd14, 16'd1000, 16'd7, 16'd6,    1'b0, 17, 0);
      run_op("div0", 4'd13, 16'd1000, 16'd0, 16'hFFFF, 1'b1, 1, 0);
    end else begin
      run_op("div",  4'd13, 16'd1000, 16'd7, 16'h0000, 1'b1, 1, 0);
      run_op("rem",  4'd14, 16'd1000, 16'd7, 16'h0000, 1'b1, 1, 0);
      run_op("div0", 4'd13, 16'd1000, 16'd0, 16'h0000, 1'b1, 1, 0);
    end
    run_op("slt",   4'd9,  16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1, 0);
    run_op("slt_ov",4'd9,  16'h8000, 16'h0001, 16'h0001, 1'b0, 1, 0);
    run_op("sle",   4'd10, 16'h1234, 16'h1234, 16'h0001, 1'b0, 1, 0);
    run_op("sco",   4'd11, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1, 0);
    run_op("rol_bp",4'd4,  16'h8001, 16'h0001, 16'h0003, 1'b0, 1, 5);
    run_op("btr",   4'd15, 16'h0001, 16'h0000, 16'h8000, 1'b0, 1, 0);
    run_op("sub",   4'd1,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1, 0);
    run_op("mulff", 4'd12, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17, 0);

    // Reset during a multiply: nothing may ever be presented for it.
    op = 4'd12; a = 16'h00FF; b = 16'h0101; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 16'h0000);
    check("midrst_z", z, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("midrst_no_result", out_valid, 0);
    end
    run_op("mul_after_rst", 4'd12, 16'd3, 16'd5, 16'd15, 1'b0, 17, 0);

    // Randomized traffic; the model compare process does the checking.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      op        = 4'($urandom_range(0, 15));
      a         = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'h0000;
        1, 2:    b = 16'($urandom_range(1, 20));
        default: b = 16'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
    end
    check("final_idle", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL take parameter WIDTH, default 16, meaning datapath width in bits (legal values 8, 16, 32).
REQ-002 SHALL take parameter SHW, default $clog2(WIDTH), meaning shift-amount width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operation request.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL have port op, input, 4 bits: operation code per REQ-013.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-009 SHALL have port out_valid, output, 1 bit: result present.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port result, output, WIDTH bits: the registered result.
REQ-012 SHALL have ports z, n, p and err, output, 1 bit each: registered flags.

Function
REQ-013 SHALL decode op as follows:
- 0 ADD, 1 SUB (a-b), 2 XOR, 3 ANDN (a&~b)
- 4 ROL, 5 SLL, 6 ROR, 7 SRL, with amount b[SHW-1:0]
- 8 SEQ, 9 SLT (signed), 10 SLE (signed), 11 SCO (carry of a+b)
- 12 MUL (low WIDTH bits, unsigned), 13 DIV (unsigned quotient), 14 REM (unsigned remainder), 15 BTR (bit reverse a)
REQ-014 SHALL produce compare ops (8-11) as result 1 or 0, zero-extended; SLT/SLE SHALL be correct on signed overflow (e.g. a=0x8000, b=0x0001 gives SLT=1).
REQ-015 SHALL implement FSM states IDLE, MUL, DIV and DONE; in_ready SHALL equal (state==IDLE).
REQ-016 SHALL register a and b and leave IDLE when in_valid && in_ready:
- ops 0-11 and 15 go to DONE, so out_valid rises on the next edge (latency 1);
- op 12 goes to MUL;
- ops 13/14 go to DIV.
REQ-017 MUL SHALL use iterative shift-add, one bit per cycle, with a counter of exactly WIDTH iterations, then DONE (latency WIDTH+1).
REQ-018 DIV SHALL use restoring division, one quotient bit per cycle, WIDTH iterations, then DONE (latency WIDTH+1).
REQ-019 DIV/REM with b==0 SHALL skip iteration and go directly to DONE with result all-ones and err=1 (latency 1).
REQ-020 err SHALL be 0 for every other case.
REQ-021 DONE SHALL hold result and the flags stable while out_valid=1 && out_ready=0.
REQ-022 On out_ready=1 in DONE, the FSM SHALL return to IDLE, so back-to-back issue interval is latency+1.
REQ-023 z SHALL be (result==0), n SHALL be result[WIDTH-1]&~z, and p SHALL be ~n&~z; all three are computed from the final result and registered with it.
REQ-024 in_valid while not in_ready SHALL be ignored; op, a and b are don't-care then.
REQ-025 Operand registers SHALL not change while in MUL or DIV.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state=IDLE, out_valid=0, result=0, z=1, n=0, p=0, err=0 and the iteration counter=0.
REQ-027 Reset asserted mid-MUL or mid-DIV SHALL abandon the operation; no result is ever presented for it.
REQ-028 in_ready SHALL be 1 on the first edge after rst_n deasserts.

Configuration
REQ-029 SHALL use macro SEQ_ALU_DIV_EN: when defined, the DIV state and divider datapath are compiled in and ops 13/14 behave per REQ-018/019.
REQ-030 Without SEQ_ALU_DIV_EN, ops 13/14 SHALL complete in 1 cycle with result=0 and err=1, and no DIV state exists.

Structure
REQ-031 Shared package seq_alu_pkg SHALL hold the op-code localparams (OP_ADD..OP_BTR) and the FSM state encoding.
REQ-032 The iterative multiply/divide datapath SHALL be one sub-module, seq_alu_muldiv (start, busy, done handshake), instantiated once.
REQ-033 Single-cycle ops SHALL be combinational logic inside seq_alu.

Verification (WIDTH=16)
REQ-034 SHALL cover ADD: a=0x7FFF, b=0x0001 -> result 0x8000, n=1, out_valid 1 cycle after accept.
REQ-035 SHALL cover MUL: a=0x0123, b=0x0010 -> result 0x1230; out_valid exactly 17 cycles after accept; in_ready=0 throughout.
REQ-036 SHALL cover DIV/REM: a=1000, b=7 -> DIV 142, REM 6; DIV with b=0 -> 0xFFFF, err=1 after 1 cycle; without macro -> 0x0000, err=1.
REQ-037 SHALL cover SLT: a=0x8000, b=0x7FFF -> 1; SLE with a=b=0x1234 -> 1; SCO: a=0xFFFF, b=0x0001 -> 1.
REQ-038 SHALL cover backpressure: hold out_ready=0 for 5 cycles after ROL a=0x8001, b=1 -> result 0x0003 stable, in_ready=0; release -> IDLE next edge.
REQ-039 SHALL cover reset mid-MUL: assert rst_n=0 at cycle 8 -> out_valid=0, result=0, z=1 immediately; the next op completes normally.
